// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor.
// One 4-bit lookahead group is resolved per stage; the group carry, the
// unresolved upper operand bits and the resolved lower sum bits travel with
// each beat. A single global stall holds every stage when the output is
// occupied and not being taken.
// Build option: define CLA_PIPE_SAT_EN to saturate sum on signed overflow
// (cout and ovf still report the raw result).
module cla_pipe_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int G = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("cla_pipe_addsub: WIDTH must be a multiple of 4 and at least 4");
    end

    // Whole pipe advances whenever the output register is free or being drained.
    assign in_ready = !out_valid || out_ready;

    for (genvar k = 0; k < G; k++) begin : g_stg
        logic             v_d, c_d;
        logic [WIDTH-1:0] a_d, b_d, s_d;
        logic             v_q, c_q;
        logic [WIDTH-1:0] a_q, b_q, s_q;
        logic [3:0]       gp, gg;
        logic [4:0]       gc;
        logic [WIDTH-1:0] s_new;

        if (k == 0) begin : g_head
            // Subtraction is a + ~b + ~borrow, so invert b and cin on entry.
            assign v_d = in_valid;
            assign a_d = a;
            assign b_d = op ? ~b : b;
            assign c_d = op ? ~cin : cin;
            assign s_d = '0;
        end else begin : g_link
            assign v_d = g_stg[k-1].v_q;
            assign a_d = g_stg[k-1].a_q;
            assign b_d = g_stg[k-1].b_q;
            assign c_d = g_stg[k-1].gc[4];
            assign s_d = g_stg[k-1].s_new;
        end

        // Stage register: captures the previous stage whenever the pipe advances.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
            end else if (in_ready) begin
                v_q <= v_d;
                c_q <= c_d;
                a_q <= a_d;
                b_q <= b_d;
                s_q <= s_d;
            end
        end

        assign gp = a_q[4*k +: 4] ^ b_q[4*k +: 4];
        assign gg = a_q[4*k +: 4] & b_q[4*k +: 4];
        assign gc[0] = c_q;
        assign gc[1] = gg[0] | (gp[0] & gc[0]);
        assign gc[2] = gg[1] | (gp[1] & gc[1]);
        assign gc[3] = gg[2] | (gp[2] & gc[2]);
        assign gc[4] = gg[3] | (gp[3] & gc[3]);

        // Merge this group's sum bits into the partial result travelling with the beat.
        always_comb begin
            s_new = s_q;
            s_new[4*k +: 4] = gp ^ gc[3:0];
        end
    end

    logic             raw_cout;
    logic             raw_ovf;
    logic [WIDTH-1:0] res;

    assign raw_cout = g_stg[G-1].gc[4];
    assign raw_ovf  = g_stg[G-1].gc[4] ^ g_stg[G-1].gc[3];

    // Result selection: wrap, or clamp toward the sign of A on overflow.
    always_comb begin
        res = g_stg[G-1].s_new;
`ifdef CLA_PIPE_SAT_EN
        if (raw_ovf) begin
            res = g_stg[G-1].a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Output register: holds while the downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (in_ready) begin
            out_valid <= g_stg[G-1].v_q;
            sum       <= res;
            cout      <= raw_cout;
            ovf       <= raw_ovf;
        end
    end
endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups. Each pipeline stage resolves one 4-bit group, and the group carry passes to the next stage. A valid/ready handshake on both sides gives one operation per cycle with full backpressure. The block is the datapath arithmetic core for wider-than-4-bit operands. It replaces the fixed 4-bit flopped adder wherever width, subtraction, carry-in, overflow or flow control is needed.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4; any other value is an elaboration error
- G (localparam), WIDTH/4, number of lookahead groups, which equals the pipeline depth

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts a beat this cycle
- op  in  1  0 = a + b + cin; 1 = a − b − cin
- a  in  WIDTH  operand A (two's complement for ovf purposes)
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; for sub, 1 = no borrow
- ovf  out  1  signed overflow of this result

## Operation
- Accept occurs when in_valid && in_ready. The stage-1 register captures a, b' = op ? ~b : b, and c0 = op ? ~cin : cin.
- Stage k (1..G) holds operands plus incoming carry c(4(k−1)). Group k−1 is computed with 4-bit lookahead: p = a^b', g = a&b', c(i+1) = g(i) | p(i)&c(i), sum bits = p^c. Sum bits are written to the next register, and c(4k) passes forward.
- Unresolved upper operand bits and already-resolved lower sum bits travel down the pipe alongside each beat. Each stage carries a valid bit.
- The final register holds sum, cout = c(WIDTH), ovf = c(WIDTH) ^ c(WIDTH−1), and out_valid.
- Global stall: in_ready = !out_valid || out_ready.
  - When in_ready = 0, every stage register and valid bit holds.
  - When in_ready = 1, all stages advance, and bubbles (valid = 0) advance too.
- Output beat completes on out_valid && out_ready. If no new beat arrives at the final stage, out_valid drops the next cycle.
- Beats exit in acceptance order. No beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge E appears on sum/cout/ovf with out_valid = 1 after edge E+G (WIDTH=16: 4 cycles). This assumes no stall. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while out_ready = 1.
- Outputs are registered, with no combinational path from a, b, op or cin to any output. in_ready depends combinationally on out_ready.
- Reset values: out_valid 0, sum 0, cout 0, ovf 0, all internal valids 0. in_ready is therefore 1 while and after rst.
- Reset mid-operation: all in-flight beats are discarded. Nothing is emitted for them after rst deasserts.
- Simultaneous accept and output handshake in the same cycle is legal and lossless.
- Held outputs are stable while out_valid && !out_ready.

## Configuration
- CLA_PIPE_SAT_EN defined: when ovf = 1, sum is replaced by a saturated value in the final stage.
  - If the sign of A (captured with the beat) is 0, sum = 0111…1.
  - If the sign of A is 1, sum = 1000…0.
  - cout and ovf still report the raw result.
- CLA_PIPE_SAT_EN undefined: sum wraps modulo 2^WIDTH. ovf is still reported.
- Latency is identical in both builds.

## Test plan
- Reset: assert rst for 3 cycles with in_valid = 1 and random operands. Required: out_valid = 0, sum = 0x0000, cout = 0, ovf = 0, in_ready = 1 throughout. No output beat appears after release.
- Carry chain (WIDTH=16): 0xFFFF + 0x0000, cin = 1, op = 0. Required: 4 cycles later sum = 0x0000, cout = 1, ovf = 0.
- Subtract: 0x0000 − 0x0001, cin = 0. Required: sum = 0xFFFF, cout = 0, ovf = 0. Next, 0x0005 − 0x0003, cin = 1. Required: sum = 0x0001, cout = 1.
- Overflow: 0x7FFF + 0x0001. Required: ovf = 1, and sum = 0x8000 (CLA_PIPE_SAT_EN undefined) or 0x7FFF (defined). Next, 0x8000 − 0x0001. Required: ovf = 1, and sum = 0x7FFF (wrap) or 0x8000 (sat).
- Backpressure: stream 8 back-to-back beats, with out_ready = 0 for 3 cycles mid-stream. Required: in_ready = 0 during the stall, held outputs unchanged, and all 8 results correct and in order.
- Reset mid-flight: accept 2 beats, then pulse rst for 1 cycle before either emerges. Required: out_valid stays 0 until a new beat is accepted. That new beat emerges after exactly G cycles.
